// File: rtl/telemetry_rx.sv
// telemetry_rx: receive-side frame parser for the e-bike telemetry link.
// Consumes bytes from UART_rx, hunts for the 0xAA 0x55 sync pair, gathers
// three 12-bit values (battery voltage, average current, average torque)
// and publishes them together. Also flags framing errors and inter-byte
// timeouts, counts errors (saturating) and tracks link health.
// Optional feature macro: TELEM_RX_RANGE_CHK_EN -- when defined, a high
// byte whose upper nibble is non-zero aborts the frame with an error.

module telemetry_rx #(
    parameter int TIMEOUT_CYC = 65536,
    parameter int LINK_CYC    = 2097152
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [11:0] batt_v,
    output logic [11:0] avg_curr,
    output logic [11:0] avg_torque,
    output logic        frm_vld,
    output logic        frm_err,
    output logic [7:0]  err_cnt,
    output logic        link_up
);

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [21:0]     LINK_MAX = 22'(LINK_CYC - 1);

    typedef enum logic [2:0] {
        HUNT  = 3'd0,
        SYNC2 = 3'd1,
        BH    = 3'd2,
        BL    = 3'd3,
        CH    = 3'd4,
        CL    = 3'd5,
        TH    = 3'd6,
        TL    = 3'd7
    } state_t;

    // Byte hand-off registers
    logic        rdy_q;
    logic        accept_q;
    logic [7:0]  byte_q;
    logic        rise_d;

    // Parser state and shadow registers
    state_t      state_q, state_d;
    logic [3:0]  bh_q, bh_d;
    logic [7:0]  bl_q, bl_d;
    logic [3:0]  ch_q, ch_d;
    logic [7:0]  cl_q, cl_d;
    logic [3:0]  th_q, th_d;
    logic        publish;
    logic        err_d;

    // Timeout tracking
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout;

    // Published outputs and status
    logic [11:0] batt_q, curr_q, torque_q;
    logic        frm_vld_q, frm_err_q;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [21:0] link_cnt_q, link_cnt_d;
    logic        link_up_q, link_up_d;

    assign rise_d = rx_rdy & ~rdy_q;

    // Detect the rising edge of rx_rdy, capture the byte and consume it once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            accept_q <= 1'b0;
            byte_q   <= 8'h00;
        end else begin
            rdy_q    <= rx_rdy;
            accept_q <= rise_d;
            if (rise_d) begin
                byte_q <= rx_data;
            end
        end
    end

    // An abandoned frame is one that sat idle too long outside HUNT; a byte
    // arriving on the expiry cycle takes priority.
    assign timeout = (state_q != HUNT) && !accept_q && (to_cnt_q == TO_MAX);

    // Frame parser: walks the sync pair and data bytes, filling shadows.
    always_comb begin
        state_d = state_q;
        bh_d    = bh_q;
        bl_d    = bl_q;
        ch_d    = ch_q;
        cl_d    = cl_q;
        th_d    = th_q;
        publish = 1'b0;
        err_d   = 1'b0;
        if (accept_q) begin
            case (state_q)
                HUNT: begin
                    if (byte_q == 8'hAA) begin
                        state_d = SYNC2;
                    end
                end
                SYNC2: begin
                    if (byte_q == 8'h55) begin
                        state_d = BH;
                    end else if (byte_q == 8'hAA) begin
                        state_d = SYNC2;
                    end else begin
                        state_d = HUNT;
                        err_d   = 1'b1;
                    end
                end
                BH: begin
`ifdef TELEM_RX_RANGE_CHK_EN
                    if (byte_q[7:4] != 4'h0) begin
                        state_d = HUNT;
                        err_d   = 1'b1;
                    end else begin
                        bh_d    = byte_q[3:0];
                        state_d = BL;
                    end
`else
                    bh_d    = byte_q[3:0];
                    state_d = BL;
`endif
                end
                BL: begin
                    bl_d    = byte_q;
                    state_d = CH;
                end
                CH: begin
`ifdef TELEM_RX_RANGE_CHK_EN
                    if (byte_q[7:4] != 4'h0) begin
                        state_d = HUNT;
                        err_d   = 1'b1;
                    end else begin
                        ch_d    = byte_q[3:0];
                        state_d = CL;
                    end
`else
                    ch_d    = byte_q[3:0];
                    state_d = CL;
`endif
                end
                CL: begin
                    cl_d    = byte_q;
                    state_d = TH;
                end
                TH: begin
`ifdef TELEM_RX_RANGE_CHK_EN
                    if (byte_q[7:4] != 4'h0) begin
                        state_d = HUNT;
                        err_d   = 1'b1;
                    end else begin
                        th_d    = byte_q[3:0];
                        state_d = TL;
                    end
`else
                    th_d    = byte_q[3:0];
                    state_d = TL;
`endif
                end
                TL: begin
                    publish = 1'b1;
                    state_d = HUNT;
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end else if (timeout) begin
            state_d = HUNT;
            err_d   = 1'b1;
        end
        if (err_d) begin
            bh_d = 4'h0;
            bl_d = 8'h00;
            ch_d = 4'h0;
            cl_d = 8'h00;
            th_d = 4'h0;
        end
    end

    // Parser state and shadow register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            bh_q    <= 4'h0;
            bl_q    <= 8'h00;
            ch_q    <= 4'h0;
            cl_q    <= 8'h00;
            th_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            bh_q    <= bh_d;
            bl_q    <= bl_d;
            ch_q    <= ch_d;
            cl_q    <= cl_d;
            th_q    <= th_d;
        end
    end

    // Inter-byte idle counter: parked at zero in HUNT, cleared by each byte.
    always_comb begin
        to_cnt_d = to_cnt_q + 1'b1;
        if ((state_q == HUNT) || accept_q || timeout) begin
            to_cnt_d = '0;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    // Error count saturates at 255 and only reset clears it.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Link watchdog: a good frame revives the link and beats the expiry.
    always_comb begin
        link_cnt_d = link_cnt_q;
        link_up_d  = link_up_q;
        if (publish) begin
            link_cnt_d = '0;
            link_up_d  = 1'b1;
        end else if (link_cnt_q == LINK_MAX) begin
            link_up_d  = 1'b0;
        end else begin
            link_cnt_d = link_cnt_q + 22'd1;
        end
    end

    // Publish all three values on one edge so no mix is ever visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            batt_q     <= 12'h000;
            curr_q     <= 12'h000;
            torque_q   <= 12'h000;
            frm_vld_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            err_cnt_q  <= 8'h00;
            link_cnt_q <= 22'd0;
            link_up_q  <= 1'b0;
        end else begin
            if (publish) begin
                batt_q   <= {bh_q, bl_q};
                curr_q   <= {ch_q, cl_q};
                torque_q <= {th_q, byte_q};
            end
            frm_vld_q  <= publish;
            frm_err_q  <= err_d;
            err_cnt_q  <= err_cnt_d;
            link_cnt_q <= link_cnt_d;
            link_up_q  <= link_up_d;
        end
    end

    assign clr_rx_rdy = accept_q;
    assign batt_v     = batt_q;
    assign avg_curr   = curr_q;
    assign avg_torque = torque_q;
    assign frm_vld    = frm_vld_q;
    assign frm_err    = frm_err_q;
    assign err_cnt    = err_cnt_q;
    assign link_up    = link_up_q;

endmodule

// File: tb/tb_telemetry_rx.sv
// Directed testbench for telemetry_rx with small timeout/link parameters.
// Honors TELEM_RX_RANGE_CHK_EN to choose the expected range-check outcome.

module tb_telemetry_rx;

    localparam int TO_CYC = 64;
    localparam int LK_CYC = 400;

    logic        clk;
    logic        rst_n;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [11:0] batt_v;
    logic [11:0] avg_curr;
    logic [11:0] avg_torque;
    logic        frm_vld;
    logic        frm_err;
    logic [7:0]  err_cnt;
    logic        link_up;

    int nCompared = 0;
    int nMismatched = 0;
    int vldSeen = 0;
    int errSeen = 0;
    int clrSeen = 0;

    telemetry_rx #(
        .TIMEOUT_CYC(TO_CYC),
        .LINK_CYC   (LK_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .clr_rx_rdy(clr_rx_rdy),
        .batt_v    (batt_v),
        .avg_curr  (avg_curr),
        .avg_torque(avg_torque),
        .frm_vld   (frm_vld),
        .frm_err   (frm_err),
        .err_cnt   (err_cnt),
        .link_up   (link_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters; registered outputs are stable at the edge they are read.
    always @(posedge clk) begin
        if (frm_vld === 1'b1) vldSeen++;
        if (frm_err === 1'b1) errSeen++;
        if (clr_rx_rdy === 1'b1) clrSeen++;
    end

    // Present one byte like UART_rx does: hold rx_rdy until it is consumed.
    task automatic applyStimulus(input logic [7:0] b);
        int guard;
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        guard   = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((clr_rx_rdy !== 1'b1) && (guard < 8));
        if (clr_rx_rdy !== 1'b1) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL byte_consume: clr_rx_rdy=%b, required 1 within 8 cycles", clr_rx_rdy);
        end
        rx_rdy = 1'b0;
    endtask

    task automatic sendFrame(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        applyStimulus(8'hAA);
        applyStimulus(8'h55);
        applyStimulus({4'h0, b[11:8]});
        applyStimulus(b[7:0]);
        applyStimulus({4'h0, c[11:8]});
        applyStimulus(c[7:0]);
        applyStimulus({4'h0, t[11:8]});
        applyStimulus(t[7:0]);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        nCompared++;
        if (batt_v !== 12'h000) begin nMismatched++; $display("[TB] FAIL reset_batt: got %h required 000", batt_v); end
        nCompared++;
        if (avg_curr !== 12'h000) begin nMismatched++; $display("[TB] FAIL reset_curr: got %h required 000", avg_curr); end
        nCompared++;
        if (avg_torque !== 12'h000) begin nMismatched++; $display("[TB] FAIL reset_torque: got %h required 000", avg_torque); end
        nCompared++;
        if ({frm_vld, frm_err, clr_rx_rdy, link_up} !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL reset_flags: got vld/err/clr/link=%b required 0000", {frm_vld, frm_err, clr_rx_rdy, link_up});
        end
        nCompared++;
        if (err_cnt !== 8'd0) begin nMismatched++; $display("[TB] FAIL reset_errcnt: got %0d required 0", err_cnt); end
    endtask

    task automatic test_good_frame;
        int v0, e0, c0;
        v0 = vldSeen; e0 = errSeen; c0 = clrSeen;
        sendFrame(12'hABC, 12'h123, 12'h7FF);
        @(negedge clk);
        nCompared++;
        if (frm_vld !== 1'b1) begin nMismatched++; $display("[TB] FAIL good_latency: frm_vld=%b required 1", frm_vld); end
        nCompared++;
        if (batt_v !== 12'hABC) begin nMismatched++; $display("[TB] FAIL good_batt: got %h required ABC", batt_v); end
        nCompared++;
        if (avg_curr !== 12'h123) begin nMismatched++; $display("[TB] FAIL good_curr: got %h required 123", avg_curr); end
        nCompared++;
        if (avg_torque !== 12'h7FF) begin nMismatched++; $display("[TB] FAIL good_torque: got %h required 7FF", avg_torque); end
        nCompared++;
        if (link_up !== 1'b1) begin nMismatched++; $display("[TB] FAIL good_link: got %b required 1", link_up); end
        @(negedge clk);
        nCompared++;
        if (frm_vld !== 1'b0) begin nMismatched++; $display("[TB] FAIL good_vld_pulse: frm_vld=%b required 0", frm_vld); end
        repeat (2) @(negedge clk);
        nCompared++;
        if (vldSeen - v0 !== 1) begin nMismatched++; $display("[TB] FAIL good_vld_count: got %0d required 1", vldSeen - v0); end
        nCompared++;
        if (clrSeen - c0 !== 8) begin nMismatched++; $display("[TB] FAIL good_clr_count: got %0d required 8", clrSeen - c0); end
        nCompared++;
        if ((errSeen - e0 !== 0) || (err_cnt !== 8'd0)) begin
            nMismatched++;
            $display("[TB] FAIL good_no_err: pulses=%0d err_cnt=%0d required 0/0", errSeen - e0, err_cnt);
        end
    endtask

    task automatic test_garbage_resync;
        int v0, e0;
        v0 = vldSeen; e0 = errSeen;
        applyStimulus(8'h13);
        applyStimulus(8'hAA);
        applyStimulus(8'hAA);
        applyStimulus(8'h55);
        applyStimulus(8'h0A);
        applyStimulus(8'hBC);
        applyStimulus(8'h01);
        applyStimulus(8'h23);
        applyStimulus(8'h07);
        applyStimulus(8'hFF);
        repeat (3) @(negedge clk);
        nCompared++;
        if (vldSeen - v0 !== 1) begin nMismatched++; $display("[TB] FAIL garbage_vld: got %0d required 1", vldSeen - v0); end
        nCompared++;
        if (errSeen - e0 !== 0) begin nMismatched++; $display("[TB] FAIL garbage_err: got %0d required 0", errSeen - e0); end
        nCompared++;
        if (batt_v !== 12'hABC) begin nMismatched++; $display("[TB] FAIL garbage_batt: got %h required ABC", batt_v); end
    endtask

    task automatic test_bad_sync;
        int v0, e0;
        v0 = vldSeen; e0 = errSeen;
        applyStimulus(8'hAA);
        applyStimulus(8'h42);
        repeat (3) @(negedge clk);
        nCompared++;
        if (errSeen - e0 !== 1) begin nMismatched++; $display("[TB] FAIL badsync_pulse: got %0d required 1", errSeen - e0); end
        nCompared++;
        if (err_cnt !== 8'd1) begin nMismatched++; $display("[TB] FAIL badsync_errcnt: got %0d required 1", err_cnt); end
        nCompared++;
        if ({batt_v, avg_curr, avg_torque} !== {12'hABC, 12'h123, 12'h7FF}) begin
            nMismatched++;
            $display("[TB] FAIL badsync_hold: got %h/%h/%h required ABC/123/7FF", batt_v, avg_curr, avg_torque);
        end
        nCompared++;
        if (vldSeen - v0 !== 0) begin nMismatched++; $display("[TB] FAIL badsync_vld: got %0d required 0", vldSeen - v0); end
    endtask

    task automatic test_timeout;
        int firstErr;
        firstErr = -1;
        applyStimulus(8'hAA);
        applyStimulus(8'h55);
        applyStimulus(8'h0A);
        for (int n = 1; n <= TO_CYC + 4; n++) begin
            @(negedge clk);
            if ((frm_err === 1'b1) && (firstErr < 0)) firstErr = n;
        end
        nCompared++;
        if (firstErr !== TO_CYC + 1) begin
            nMismatched++;
            $display("[TB] FAIL timeout_cycle: frm_err at idle cycle %0d required %0d", firstErr, TO_CYC + 1);
        end
        nCompared++;
        if (err_cnt !== 8'd2) begin nMismatched++; $display("[TB] FAIL timeout_errcnt: got %0d required 2", err_cnt); end
        sendFrame(12'h5A5, 12'h3C3, 12'h0F0);
        repeat (2) @(negedge clk);
        nCompared++;
        if ({batt_v, avg_curr, avg_torque} !== {12'h5A5, 12'h3C3, 12'h0F0}) begin
            nMismatched++;
            $display("[TB] FAIL timeout_recover: got %h/%h/%h required 5A5/3C3/0F0", batt_v, avg_curr, avg_torque);
        end
    endtask

    task automatic test_range_check;
        int v0, e0;
        v0 = vldSeen; e0 = errSeen;
        applyStimulus(8'hAA);
        applyStimulus(8'h55);
        applyStimulus(8'h1A);
        applyStimulus(8'hBC);
        applyStimulus(8'h01);
        applyStimulus(8'h23);
        applyStimulus(8'h07);
        applyStimulus(8'hFF);
        repeat (3) @(negedge clk);
`ifdef TELEM_RX_RANGE_CHK_EN
        nCompared++;
        if ((errSeen - e0 !== 1) || (vldSeen - v0 !== 0)) begin
            nMismatched++;
            $display("[TB] FAIL range_reject: err=%0d vld=%0d required 1/0", errSeen - e0, vldSeen - v0);
        end
        nCompared++;
        if (batt_v !== 12'h5A5) begin nMismatched++; $display("[TB] FAIL range_hold: got %h required 5A5", batt_v); end
`else
        nCompared++;
        if ((errSeen - e0 !== 0) || (vldSeen - v0 !== 1)) begin
            nMismatched++;
            $display("[TB] FAIL range_ignore: err=%0d vld=%0d required 0/1", errSeen - e0, vldSeen - v0);
        end
        nCompared++;
        if (batt_v !== 12'hABC) begin nMismatched++; $display("[TB] FAIL range_batt: got %h required ABC", batt_v); end
`endif
    endtask

    task automatic test_link_timeout;
        int firstLow;
        firstLow = -1;
        sendFrame(12'h111, 12'h222, 12'h333);
        for (int n = 1; n <= LK_CYC + 5; n++) begin
            @(negedge clk);
            if ((link_up !== 1'b1) && (firstLow < 0)) firstLow = n;
        end
        nCompared++;
        if (firstLow !== LK_CYC + 1) begin
            nMismatched++;
            $display("[TB] FAIL link_drop: link_up fell at cycle %0d required %0d", firstLow, LK_CYC + 1);
        end
        nCompared++;
        if (link_up !== 1'b0) begin nMismatched++; $display("[TB] FAIL link_stay_low: got %b required 0", link_up); end
    endtask

    task automatic test_err_saturation;
        int e0;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(8'hAA);
            applyStimulus(8'h42);
        end
        repeat (2) @(negedge clk);
        nCompared++;
        if (err_cnt !== 8'd255) begin nMismatched++; $display("[TB] FAIL sat_reach: got %0d required 255", err_cnt); end
        e0 = errSeen;
        applyStimulus(8'hAA);
        applyStimulus(8'h42);
        repeat (3) @(negedge clk);
        nCompared++;
        if (err_cnt !== 8'd255) begin nMismatched++; $display("[TB] FAIL sat_hold: got %0d required 255", err_cnt); end
        nCompared++;
        if (errSeen - e0 !== 1) begin nMismatched++; $display("[TB] FAIL sat_pulse: got %0d required 1", errSeen - e0); end
    endtask

    task automatic test_reset_midframe;
        int v0;
        applyStimulus(8'hAA);
        applyStimulus(8'h55);
        applyStimulus(8'h0A);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        nCompared++;
        if ({batt_v, avg_curr, avg_torque} !== 36'h0) begin
            nMismatched++;
            $display("[TB] FAIL midreset_outputs: got %h/%h/%h required 000/000/000", batt_v, avg_curr, avg_torque);
        end
        nCompared++;
        if ((err_cnt !== 8'd0) || (link_up !== 1'b0)) begin
            nMismatched++;
            $display("[TB] FAIL midreset_status: err_cnt=%0d link_up=%b required 0/0", err_cnt, link_up);
        end
        rst_n = 1'b1;
        v0 = vldSeen;
        applyStimulus(8'hBC);
        applyStimulus(8'h01);
        applyStimulus(8'h23);
        applyStimulus(8'h07);
        applyStimulus(8'hFF);
        repeat (3) @(negedge clk);
        nCompared++;
        if ((vldSeen - v0 !== 0) || (batt_v !== 12'h000)) begin
            nMismatched++;
            $display("[TB] FAIL midreset_lost: vld=%0d batt=%h required 0/000", vldSeen - v0, batt_v);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_garbage_resync();
        test_bad_sync();
        test_timeout();
        test_range_check();
        test_link_timeout();
        test_err_saturation();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
